logo_bouncer: RTL

//  Pixel stage directly downstream of the VGA video timer. Holds a LOGO_W x LOGO_H

---
 rtl/logo_bouncer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/logo_bouncer.sv
// Pixel stage after the VGA timer: a rectangle that bounces diagonally once per frame,
// cycling a 6-colour palette on every bounce, with a 2-stage registered RGB/sync path.
module logo_bouncer #(
  parameter int H_VISIBLE = 640,
  parameter int V_VISIBLE = 480,
  parameter int LOGO_W    = 64,
  parameter int LOGO_H    = 32,
  parameter int SPEED     = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         hsync_in,
  input  logic                         vsync_in,
  input  logic                         visible_in,
  input  logic [$clog2(H_VISIBLE)-1:0] position_x,
  input  logic [$clog2(V_VISIBLE)-1:0] position_y,
  output logic [3:0]                   vga_r,
  output logic [3:0]                   vga_g,
  output logic [3:0]                   vga_b,
  output logic                         hsync,
  output logic                         vsync,
  output logic [$clog2(H_VISIBLE)-1:0] logo_x,
  output logic [$clog2(V_VISIBLE)-1:0] logo_y,
  output logic [15:0]                  corner_count
);

  localparam int XW = $clog2(H_VISIBLE);
  localparam int YW = $clog2(V_VISIBLE);

  // One extra bit on every position compare so edge tests never wrap.
  localparam logic [XW:0] X_MAX_W  = (XW+1)'(H_VISIBLE - LOGO_W);
  localparam logic [YW:0] Y_MAX_W  = (YW+1)'(V_VISIBLE - LOGO_H);
  localparam logic [XW:0] SPEED_XW = (XW+1)'(SPEED);
  localparam logic [YW:0] SPEED_YW = (YW+1)'(SPEED);
  localparam logic [XW:0] LOGO_WW  = (XW+1)'(LOGO_W);
  localparam logic [YW:0] LOGO_HW  = (YW+1)'(LOGO_H);

  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_t;

  dir_t          dx, dy, dx_next, dy_next;
  logic [XW-1:0] x_next;
  logic [YW-1:0] y_next;
  logic          x_hit, y_hit;
  logic [XW:0]   x_w, x_inc, x_dec;
  logic [YW:0]   y_w, y_inc, y_dec;
  logic [2:0]    color_idx;
  logic          vsync_hist;
  logic          tick;

  logic          s1_in_logo, s1_hsync, s1_vsync;
  logic          in_x, in_y;
  logic [XW:0]   px_w, x_end;
  logic [YW:0]   py_w, y_end;
  logic [11:0]   rgb_next;

  function automatic logic [11:0] palette(input logic [2:0] idx);
    case (idx)
      3'd0:    palette = 12'hF00;
      3'd1:    palette = 12'hFF0;
      3'd2:    palette = 12'h0F0;
      3'd3:    palette = 12'h0FF;
      3'd4:    palette = 12'h00F;
      3'd5:    palette = 12'hF0F;
      default: palette = 12'h000;
    endcase
  endfunction

  // Falling edge of vsync_in: exactly one motion tick per frame, in vertical blank.
  assign tick = vsync_hist & ~vsync_in;

  always_comb begin
    x_w     = {1'b0, logo_x};
    x_inc   = x_w + SPEED_XW;
    x_dec   = x_w - SPEED_XW;
    x_next  = logo_x;
    dx_next = dx;
    x_hit   = 1'b0;
    if (dx == DIR_POS) begin
      if (x_inc >= X_MAX_W) begin
        x_next  = X_MAX_W[XW-1:0];
        dx_next = DIR_NEG;
        x_hit   = 1'b1;
      end else begin
        x_next  = x_inc[XW-1:0];
      end
    end else begin
      if (x_w <= SPEED_XW) begin
        x_next  = '0;
        dx_next = DIR_POS;
        x_hit   = 1'b1;
      end else begin
        x_next  = x_dec[XW-1:0];
      end
    end
  end

  always_comb begin
    y_w     = {1'b0, logo_y};
    y_inc   = y_w + SPEED_YW;
    y_dec   = y_w - SPEED_YW;
    y_next  = logo_y;
    dy_next = dy;
    y_hit   = 1'b0;
    if (dy == DIR_POS) begin
      if (y_inc >= Y_MAX_W) begin
        y_next  = Y_MAX_W[YW-1:0];
        dy_next = DIR_NEG;
        y_hit   = 1'b1;
      end else begin
        y_next  = y_inc[YW-1:0];
      end
    end else begin
      if (y_w <= SPEED_YW) begin
        y_next  = '0;
        dy_next = DIR_POS;
        y_hit   = 1'b1;
      end else begin
        y_next  = y_dec[YW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_hist   <= 1'b1;
      logo_x       <= '0;
      logo_y       <= '0;
      dx           <= DIR_POS;
      dy           <= DIR_POS;
      color_idx    <= '0;
      corner_count <= '0;
    end else begin
      vsync_hist <= vsync_in;
      if (tick) begin
        logo_x <= x_next;
        logo_y <= y_next;
        dx     <= dx_next;
        dy     <= dy_next;
        if (x_hit || y_hit)
          color_idx <= (color_idx == 3'd5) ? 3'd0 : color_idx + 3'd1;
        if (x_hit && y_hit && (corner_count != '1))
          corner_count <= corner_count + 16'd1;
      end
    end
  end

  always_comb begin
    px_w  = {1'b0, position_x};
    py_w  = {1'b0, position_y};
    x_end = {1'b0, logo_x} + LOGO_WW;
    y_end = {1'b0, logo_y} + LOGO_HW;
    in_x  = (position_x >= logo_x) && (px_w < x_end);
    in_y  = (position_y >= logo_y) && (py_w < y_end);
  end

  assign rgb_next = s1_in_logo ? palette(color_idx) : 12'h000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_in_logo <= 1'b0;
      s1_hsync   <= 1'b1;
      s1_vsync   <= 1'b1;
      vga_r      <= '0;
      vga_g      <= '0;
      vga_b      <= '0;
      hsync      <= 1'b1;
      vsync      <= 1'b1;
    end else begin
      s1_in_logo <= visible_in & in_x & in_y;
      s1_hsync   <= hsync_in;
      s1_vsync   <= vsync_in;
      vga_r      <= rgb_next[11:8];
      vga_g      <= rgb_next[7:4];
      vga_b      <= rgb_next[3:0];
      hsync      <= s1_hsync;
      vsync      <= s1_vsync;
    end
  end

endmodule
